rv32_decode_stage: RTL and testbench
====================================

Name: rv32_decode_stage

Overview:
Pipelined RV32I instruction decoder, the inverse of the team's opcode encoder functions (encode_rtype … encode_jtype) in the opcodes package. It accepts raw 32-bit instruction words with PC over a valid/ready handshake. It emits a registered decoded bundle: mnemonic, format, execution unit, register numbers, sign-extended immediate, plus illegal and halt flags. It sits between fetch and issue, and includes a skid buffer and a halt state machine.

Parameters:
XLEN, 32, datapath and PC width; only 32 is supported.
HALT_WORD, 32'h00010073, instruction word that triggers halt.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous; drops all held instructions and returns the state machine to RUN.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_instr  in  32  raw instruction word.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream accepts the bundle.
out_pc  out  XLEN  PC passed through unchanged.
out_mnemonic  out  6  mnemonic_t code (ADDI=0 … SB=35); LB=6'd36.
out_op_type  out  3  op_type_t code (R_TYPE=0 … J_TYPE=5).
out_unit  out  3  proc_unit_t code (ALU=0, BRU=1, MAU=2).
out_rd, out_rs1, out_rs2  out  5 each  register numbers; 0 when the format has no such field.
out_imm  out  32  decoded immediate.
out_illegal  out  1  word matched no opcode mask.
out_halt  out  1  word equals HALT_WORD.

Behaviour:
- Reset: all outputs 0, both buffer slots empty, state RUN.
- Pipeline:
  - One output register plus one skid register.
  - An instruction accepted in cycle N appears on out_* in cycle N+1 if the output register is free or being drained.
  - in_ready = (state==RUN) && skid empty, registered, so it has no combinational path from out_ready.
  - Transfer happens on valid&&ready at each side.
  - When the output is stalled and an input is accepted, the input goes to the skid register. The skid register moves to the output when the output drains.
  - Order is strictly preserved.
  - While out_valid=1 and out_ready=0, out_* stay stable.
- Decode, matching the opcodes package masks with don't-care bits:
  - Register fields are taken per format:
    - rd for R, I, U, J.
    - rs1 for R, I, S, B.
    - rs2 for R, S, B.
  - out_imm:
    - I: sext(instr[31:20]); for SLLI/SRLI/SRAI it is zext(instr[24:20]).
    - S: sext({instr[31:25],instr[11:7]}).
    - B: sext({instr[31],instr[7],instr[30:25],instr[11:8]}), i.e. the raw 12-bit field value, exactly inverting encode_btype.
    - U: {instr[31:12],12'b0}.
    - J: sext({instr[31],instr[19:12],instr[20],instr[30:21]}), inverting encode_jtype.
    - R: 0.
  - Unit: ALU for arithmetic/logic/shift/LUI/AUIPC; BRU for JAL/JALR/branches; MAU for loads/stores. JALR is I_TYPE/BRU.
  - HALT_WORD is checked first: out_halt=1, out_illegal=0, all other fields 0.
  - Any other unmatched word: out_illegal=1, mnemonic/type/unit/regs/imm all 0.
- State machine:
  - RUN: normal operation. Accepting HALT_WORD moves to HALTED in the next cycle.
  - HALTED: in_ready=0. Instructions already buffered still drain, including the halt bundle.
  - flush returns the state machine to RUN from any state.
- Flush:
  - Clears out_valid and the skid register in the next cycle.
  - An input handshake in the same cycle as flush is discarded.
  - in_ready is 1 the cycle after flush.
- Reset asserted mid-transfer: buffered data is lost and outputs go to 0 immediately (asynchronous).

Test Plan:
- Single ADDI: in_instr=32'hFFD30293 (ADDI x5,x6,-3), out_ready=1 → next cycle out_mnemonic=0, op_type=1, unit=0, rd=5, rs1=6, rs2=0, imm=32'hFFFFFFFD.
- ADD then BEQ, back-to-back, out_ready=1:
  - 32'h003100B3 → mnemonic=11, rd=1, rs1=2, rs2=3, imm=0.
  - 32'hFE208CE3 → mnemonic=23, type=3, unit=1, rs1=1, rs2=2, imm=32'hFFFFFFFC.
  - Throughput is one per cycle.
- Backpressure: stream 4 instructions while holding out_ready=0 for 3 cycles → out_* stable, in_ready drops after the skid fills, all 4 are delivered in order with none lost or duplicated.
- Halt: 32'h00010073 followed by valid ADDI → out_halt=1, out_illegal=0, in_ready=0, ADDI not accepted; flush → in_ready=1, ADDI then accepted.
- Illegal: in_instr=32'h00000000 → out_illegal=1, all fields 0.
- Reset and flush mid-stall: reset_n=0 during a stall → outputs 0 asynchronously; flush coincident with in_valid → that input is dropped and out_valid=0 in the next cycle.

Source files
------------

// File: rtl/rv32_decode_stage_if.sv
// rtl/rv32_decode_stage_if.sv - fetch-side instruction handshake and issue-side decoded bundle
interface rv32_decode_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [5:0]      out_mnemonic;
  logic [2:0]      out_op_type;
  logic [2:0]      out_unit;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [31:0]     out_imm;
  logic            out_illegal;
  logic            out_halt;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_mnemonic, out_op_type, out_unit,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_halt
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_mnemonic, out_op_type, out_unit,
           out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_halt
  );
endinterface

// File: rtl/rv32_decode_stage.sv
// rtl/rv32_decode_stage.sv - RV32I decode stage with output/skid registers and halt FSM
module rv32_decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] HALT_WORD = 32'h00010073
) (
  input  logic              clk,
  input  logic              reset_n,
  rv32_decode_stage_if.slave bus
);

  localparam logic [2:0] R_TYPE = 3'd0, I_TYPE = 3'd1, S_TYPE = 3'd2,
                         B_TYPE = 3'd3, U_TYPE = 3'd4, J_TYPE = 3'd5;
  localparam logic [2:0] ALU = 3'd0, BRU = 3'd1, MAU = 3'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      mnemonic;
    logic [2:0]      op_type;
    logic [2:0]      unit;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic            illegal;
    logic            halt;
  } bundle_t;

  typedef enum logic {RUN, HALTED} state_t;

  function automatic bundle_t decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
    bundle_t    b;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    b    = '0;
    b.pc = pc;
    ok   = 1'b1;
    f3   = w[14:12];
    f7   = w[31:25];
    if (w == HALT_WORD) begin
      b.halt = 1'b1;
      return b;
    end
    case (w[6:0])
      7'h13: begin
        b.op_type = I_TYPE;
        b.unit    = ALU;
        case (f3)
          3'd0:    b.mnemonic = 6'd0;
          3'd2:    b.mnemonic = 6'd1;
          3'd3:    b.mnemonic = 6'd2;
          3'd4:    b.mnemonic = 6'd3;
          3'd6:    b.mnemonic = 6'd4;
          3'd7:    b.mnemonic = 6'd5;
          3'd1: begin
            b.mnemonic = 6'd6;
            ok         = (f7 == 7'h00);
          end
          default: begin
            b.mnemonic = (f7 == 7'h20) ? 6'd8 : 6'd7;
            ok         = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      7'h37: begin b.op_type = U_TYPE; b.unit = ALU; b.mnemonic = 6'd9;  end
      7'h17: begin b.op_type = U_TYPE; b.unit = ALU; b.mnemonic = 6'd10; end
      7'h33: begin
        b.op_type = R_TYPE;
        b.unit    = ALU;
        ok        = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        case (f3)
          3'd0:    b.mnemonic = f7[5] ? 6'd12 : 6'd11;
          3'd1:    b.mnemonic = 6'd13;
          3'd2:    b.mnemonic = 6'd14;
          3'd3:    b.mnemonic = 6'd15;
          3'd4:    b.mnemonic = 6'd16;
          3'd5:    b.mnemonic = f7[5] ? 6'd18 : 6'd17;
          3'd6:    b.mnemonic = 6'd19;
          default: b.mnemonic = 6'd20;
        endcase
      end
      7'h6F: begin b.op_type = J_TYPE; b.unit = BRU; b.mnemonic = 6'd21; end
      7'h67: begin
        b.op_type  = I_TYPE;
        b.unit     = BRU;
        b.mnemonic = 6'd22;
        ok         = (f3 == 3'd0);
      end
      7'h63: begin
        b.op_type = B_TYPE;
        b.unit    = BRU;
        case (f3)
          3'd0:    b.mnemonic = 6'd23;
          3'd1:    b.mnemonic = 6'd24;
          3'd4:    b.mnemonic = 6'd25;
          3'd5:    b.mnemonic = 6'd26;
          3'd6:    b.mnemonic = 6'd27;
          3'd7:    b.mnemonic = 6'd28;
          default: ok = 1'b0;
        endcase
      end
      7'h03: begin
        b.op_type = I_TYPE;
        b.unit    = MAU;
        // LB was appended after the other loads, hence its out-of-order code
        case (f3)
          3'd0:    b.mnemonic = 6'd36;
          3'd1:    b.mnemonic = 6'd30;
          3'd2:    b.mnemonic = 6'd29;
          3'd4:    b.mnemonic = 6'd32;
          3'd5:    b.mnemonic = 6'd31;
          default: ok = 1'b0;
        endcase
      end
      7'h23: begin
        b.op_type = S_TYPE;
        b.unit    = MAU;
        case (f3)
          3'd0:    b.mnemonic = 6'd35;
          3'd1:    b.mnemonic = 6'd34;
          3'd2:    b.mnemonic = 6'd33;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    case (b.op_type)
      R_TYPE: begin
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
      end
      I_TYPE: begin
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        if ((w[6:0] == 7'h13) && (f3[1:0] == 2'b01))
          b.imm = {27'b0, w[24:20]};
        else
          b.imm = {{20{w[31]}}, w[31:20]};
      end
      S_TYPE: begin
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      B_TYPE: begin
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.imm = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
      end
      U_TYPE: begin
        b.rd  = w[11:7];
        b.imm = {w[31:12], 12'b0};
      end
      default: begin
        b.rd  = w[11:7];
        b.imm = {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
      end
    endcase
    if (!ok) begin
      b         = '0;
      b.pc      = pc;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  bundle_t out_q;
  bundle_t skid_q;
  bundle_t dec;
  logic    out_valid_q;
  logic    skid_valid_q;
  logic    in_ready_q;
  state_t  state;
  state_t  state_nx;
  logic    accept;
  logic    out_free;
  logic    skid_nx;

  always_comb begin
    dec      = decode(bus.in_instr, bus.in_pc);
    accept   = bus.in_valid && in_ready_q;
    out_free = !out_valid_q || bus.out_ready;
    // in_ready high guarantees an empty skid, so a drain never collides with a new fill
    skid_nx  = out_free ? 1'b0 : (skid_valid_q || accept);
    state_nx = (accept && dec.halt) ? HALTED : state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      state        <= RUN;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      state        <= RUN;
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else if (accept) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= dec;
      end
      skid_valid_q <= skid_nx;
      state        <= state_nx;
      in_ready_q   <= (state_nx == RUN) && !skid_nx;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_mnemonic = out_q.mnemonic;
  assign bus.out_op_type  = out_q.op_type;
  assign bus.out_unit     = out_q.unit;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_illegal  = out_q.illegal;
  assign bus.out_halt     = out_q.halt;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb/tb_rv32_decode_stage.sv - randomized and directed bench against a table-driven RV32I model
module tb_rv32_decode_stage;
    localparam logic [31:0] HALT = 32'h00010073;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rv32_decode_stage_if #(.XLEN(32)) bus();
    rv32_decode_stage #(.XLEN(32), .HALT_WORD(HALT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  mnem;
        logic [2:0]  typ;
        logic [2:0]  unit;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic        halt;
    } exp_t;

    localparam logic [31:0] MATCH [37] = '{
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013, 32'h00000037, 32'h00000017,
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
        32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
        32'h0000006F, 32'h00000067, 32'h00000063, 32'h00001063, 32'h00004063,
        32'h00005063, 32'h00006063, 32'h00007063, 32'h00002003, 32'h00001003,
        32'h00005003, 32'h00004003, 32'h00002023, 32'h00001023, 32'h00000023,
        32'h00000003};
    localparam logic [31:0] MASK [37] = '{
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'h0000007F, 32'h0000007F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000007F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F};

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t       e;
        int         idx;
        logic [6:0] opc;
        e    = '0;
        e.pc = pc;
        idx  = -1;
        opc  = w[6:0];
        if (w == HALT) begin
            e.halt = 1'b1;
            return e;
        end
        for (int i = 0; i < 37; i++)
            if ((w & MASK[i]) == MATCH[i]) idx = i;
        if (idx < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.mnem = idx[5:0];
        e.unit = (opc == 7'h6F || opc == 7'h67 || opc == 7'h63) ? 3'd1 :
                 (opc == 7'h03 || opc == 7'h23) ? 3'd2 : 3'd0;
        case (opc)
            7'h33: begin e.typ = 3'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            7'h13, 7'h67, 7'h03: begin
                e.typ = 3'd1; e.rd = w[11:7]; e.rs1 = w[19:15];
                e.imm = (idx >= 6 && idx <= 8) ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
            end
            7'h23: begin
                e.typ = 3'd2; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h63: begin
                e.typ = 3'd3; e.rs1 = w[19:15]; e.rs2 = w[24:20];
                e.imm = {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
            end
            7'h37, 7'h17: begin e.typ = 3'd4; e.rd = w[11:7]; e.imm = {w[31:12], 12'b0}; end
            default: begin
                e.typ = 3'd5; e.rd = w[11:7];
                e.imm = {{12{w[31]}}, w[31], w[19:12], w[20], w[30:21]};
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        int          i;
        if ($urandom_range(0, 9) == 0) begin
            w = $urandom;
        end else begin
            i = $urandom_range(0, 36);
            w = ($urandom & ~MASK[i]) | MATCH[i];
        end
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    function automatic exp_t observed();
        return {bus.out_pc, bus.out_mnemonic, bus.out_op_type, bus.out_unit, bus.out_rd,
                bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_illegal, bus.out_halt};
    endfunction

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.out_ready = 1'b1; reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, observed()} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.out_valid, bus.in_ready, observed()});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        e = '{32'h100, 6'd0, 3'd1, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0};
        bus.in_valid = 1'b1; bus.in_instr = 32'hFFD30293; bus.in_pc = 32'h100; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL addi valid=%b got=%h exp=%h", bus.out_valid, observed(), e);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL addi_drain out_valid=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e_add, e_beq;
        e_add = '{32'h40, 6'd11, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0};
        e_beq = '{32'h44, 6'd23, 3'd3, 3'd1, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b0};
        bus.in_valid = 1'b1; bus.in_instr = 32'h003100B3; bus.in_pc = 32'h40;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e_add || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_add valid=%b ready=%b got=%h exp=%h", bus.out_valid, bus.in_ready, observed(), e_add);
        end
        bus.in_instr = 32'hFE208CE3; bus.in_pc = 32'h44;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== e_beq) begin
            failures++;
            $display("FAIL b2b_beq valid=%b got=%h exp=%h", bus.out_valid, observed(), e_beq);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t        q[$];
        exp_t        prev;
        logic [31:0] ws[4];
        int          sent, got;
        bit          drop_seen, prev_stall;
        sent = 0; got = 0; drop_seen = 0; prev_stall = 0; prev = '0;
        for (int i = 0; i < 4; i++) ws[i] = gen_word();
        for (int c = 0; c < 20; c++) begin
            bus.out_ready = (c >= 3);
            bus.in_valid  = (sent < 4);
            bus.in_instr  = ws[sent % 4];
            bus.in_pc     = 32'h200 + 32'(4 * sent);
            if (!bus.in_ready && sent < 4) drop_seen = 1;
            if (prev_stall) begin
                checks++;
                if (observed() !== prev) begin
                    failures++;
                    $display("FAIL bp_stable got=%h exp=%h", observed(), prev);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_instr, bus.in_pc));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0 || observed() !== q[0]) begin
                    failures++;
                    $display("FAIL bp_order got=%h pending=%0d", observed(), q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = observed();
            @(negedge clk);
        end
        checks++;
        if (got != 4 || q.size() != 0 || !drop_seen) begin
            failures++;
            $display("FAIL bp_count delivered=%0d pending=%0d ready_dropped=%0d exp 4/0/1", got, q.size(), drop_seen);
        end
        idle(1);
    endtask

    task automatic test_halt();
        exp_t e, g;
        e = '0; e.halt = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = HALT; bus.in_pc = 32'h300; bus.out_ready = 1'b1;
        @(negedge clk);
        g = observed(); g.pc = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || g !== e || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_bundle valid=%b ready=%b got=%h exp=%h", bus.out_valid, bus.in_ready, g, e);
        end
        bus.in_instr = 32'hFFD30293; bus.in_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL halted_hold ready=%b valid=%b exp 0/0", bus.in_ready, bus.out_valid);
            end
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_flush ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== model(32'hFFD30293, 32'h304)) begin
            failures++;
            $display("FAIL halt_resume valid=%b got=%h exp=%h", bus.out_valid, observed(), model(32'hFFD30293, 32'h304));
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [31:0] ws[6];
        exp_t        e, g;
        ws = '{32'h00000000, 32'hFFFFFFFF, 32'h0000100F, 32'h02000033, 32'h40001013, 32'h00100073};
        e = '0; e.illegal = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = ws[i]; bus.in_pc = 32'h500 + 32'(4 * i);
            @(negedge clk);
            g = observed(); g.pc = '0;
            checks++;
            if (bus.out_valid !== 1'b1 || g !== e) begin
                failures++;
                $display("FAIL illegal_%0d word=%h valid=%b got=%h exp=%h", i, ws[i], bus.out_valid, g, e);
            end
        end
        idle(1);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h003100B3; bus.in_pc = 32'h600;
        @(negedge clk);
        bus.flush = 1'b1; bus.in_instr = 32'hFE208CE3; bus.in_pc = 32'h604;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_same_cycle valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_dropped valid=%b exp 0", bus.out_valid);
            end
        end
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h00000013;
        @(negedge clk);
        bus.in_instr = 32'h00100093;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_skid_full ready=%b exp 0", bus.in_ready);
        end
        bus.in_valid = 1'b0; bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_skid valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_skid_cleared valid=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'hFFD30293; bus.in_pc = 32'h700;
        @(negedge clk);
        bus.in_instr = 32'h003100B3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre valid=%b exp 1", bus.out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, observed()} !== '0) begin
            failures++;
            $display("FAIL rstmid_async got=%h exp=0", {bus.out_valid, bus.in_ready, observed()});
        end
        @(negedge clk);
        reset_n = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t prev;
        bit   prev_stall;
        int   drain;
        prev_stall = 0; prev = '0;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.in_instr  = gen_word();
            bus.in_pc     = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            if (prev_stall) begin
                checks++;
                if (observed() !== prev) begin
                    failures++;
                    $display("FAIL rand_stable got=%h exp=%h", observed(), prev);
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_instr, bus.in_pc));
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0 || observed() !== q[0]) begin
                    failures++;
                    $display("FAIL rand_bundle got=%h exp=%h", observed(), (q.size() != 0) ? q[0] : exp_t'('0));
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = observed();
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drain = 0;
        while (drain < 10) begin
            if (bus.out_valid) begin
                checks++;
                if (q.size() == 0 || observed() !== q[0]) begin
                    failures++;
                    $display("FAIL rand_drain got=%h pending=%0d", observed(), q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            drain++;
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_leftover pending=%0d valid=%b exp 0/0", q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_halt();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

endmodule
